// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART receive path.
// Pure declarations: no latency, no handshake.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int baud_div(input longint clk_freq, input longint baud);
    return int'(clk_freq / (baud * OVERSAMPLE));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO; head word is visible combinationally.
// Push while full is taken only alongside a pop; pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  // Empty head reads as zero so the output never shows a stale word.
  assign pop_dat = empty ? '0 : mem_q[rd_ptr_q];
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/uart_rx_buffered.sv
// 16x-oversampled UART receiver with parity/stop checking feeding a FWFT FIFO.
// Word appears one clock after the final stop sample; a full FIFO drops frames unless popped that cycle.
module uart_rx_buffered #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 19200,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    rx,
  output logic [DATA_WIDTH-1:0]   rdData,
  output logic                    rdValid,
  input  logic                    rdReady,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    parityErr,
  output logic                    frameErr,
  output logic                    overflow,
  input  logic                    clrErr
);
  import uart_pkg::*;

  localparam int         DIV      = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int         DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam parity_t    PAR_MODE = parity_t'(PARITY);
  localparam logic [3:0] MID      = 4'd7;

  rx_state_t             state_q, state_d;
  logic                  rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [3:0]            smp_cnt_q, smp_cnt_d, bit_cnt_q, bit_cnt_d;
  logic [1:0]            stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bit_q, par_bit_d, stop_bad_q, stop_bad_d;
  logic                  par_err_q, par_err_d, frm_err_q, frm_err_d, ovf_q, ovf_d;
  logic                  tick, mid, fall, last_stop, stop_low, par_ok, good;
  logic                  push, pop, fifo_full, fifo_empty;

  always_comb begin
    tick      = (div_cnt_q == DIV_W'(DIV - 1));
    mid       = tick && (smp_cnt_q == MID);
    fall      = rx_prev_q && !rx_s2_q;
    last_stop = (state_q == STOP) && mid && (stop_cnt_q == 2'(STOP_BITS - 1));
    stop_low  = stop_bad_q || !rx_s2_q;
    case (PAR_MODE)
      PAR_ODD:  par_ok = ^{shift_q, par_bit_q};
      PAR_EVEN: par_ok = ~^{shift_q, par_bit_q};
      default:  par_ok = 1'b1;
    endcase
    good = last_stop && !stop_low && par_ok;
    pop  = rdValid && rdReady;
    push = good && (!fifo_full || pop);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:             if (fall) state_d = START;
      START:            if (mid) state_d = rx_s2_q ? IDLE : DATA;
      DATA:             if (mid && bit_cnt_q == 4'(DATA_WIDTH - 1))
                          state_d = (PAR_MODE == PAR_NONE) ? STOP : uart_pkg::PARITY;
      uart_pkg::PARITY: if (mid) state_d = STOP;
      STOP:             if (last_stop) state_d = stop_low ? BREAK : IDLE;
      BREAK:            if (rx_s2_q) state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_s1_d    = rx;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
    smp_cnt_d  = tick ? smp_cnt_q + 4'd1 : smp_cnt_q;
    if (state_q == IDLE && fall) smp_cnt_d = '0;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    if (state_q == START) bit_cnt_d = '0;
    if (state_q == DATA && mid) begin
      bit_cnt_d = bit_cnt_q + 4'd1;
      shift_d   = {rx_s2_q, shift_q[DATA_WIDTH-1:1]};
    end
    par_bit_d  = (state_q == uart_pkg::PARITY && mid) ? rx_s2_q : par_bit_q;
    stop_cnt_d = (state_q != STOP) ? '0 : (mid ? stop_cnt_q + 2'd1 : stop_cnt_q);
    stop_bad_d = (state_q != STOP) ? 1'b0 : (stop_bad_q || (mid && !rx_s2_q));
    // A set in the same cycle as clrErr must survive.
    frm_err_d  = (last_stop && stop_low) || (frm_err_q && !clrErr);
    par_err_d  = (last_stop && !stop_low && !par_ok) || (par_err_q && !clrErr);
    ovf_d      = (good && fifo_full && !pop) || (ovf_q && !clrErr);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      div_cnt_q  <= '0;
      smp_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      div_cnt_q  <= div_cnt_d;
      smp_cnt_q  <= smp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      stop_bad_q <= stop_bad_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      ovf_q      <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstN     (rstN),
    .push     (push),
    .push_dat (shift_q),
    .pop      (pop),
    .pop_dat  (rdData),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count)
  );

  assign rdValid   = !fifo_empty;
  assign parityErr = par_err_q;
  assign frameErr  = frm_err_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: an 8N1 port (a) and an 8E1 port (b), both 4 deep.
// 64 clocks per bit keeps whole frames short.
module tb_uart_rx_buffered;
  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rstN, rx_a, rx_b, rdReady_a, rdReady_b, clrErr_a, clrErr_b;
  logic [7:0] rdData_a, rdData_b;
  logic       rdValid_a, rdValid_b;
  logic [2:0] count_a, count_b;
  logic       parityErr_a, frameErr_a, overflow_a, parityErr_b, frameErr_b, overflow_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fclk, push_at, n04;
  int pop_at = -1;
  logic [2:0] prev_cnt, cur_cnt, snap_cnt;
  logic [7:0] snap_dat, pre_dat, d77, e;
  logic       snap_ovf;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_buffered #(.DATA_WIDTH(8), .CLK_FREQ(64_000_000), .BAUD_RATE(1_000_000),
                     .PARITY(0), .STOP_BITS(1), .DEPTH(4)) dut_a (
    .clk(clk), .rstN(rstN), .rx(rx_a), .rdData(rdData_a), .rdValid(rdValid_a),
    .rdReady(rdReady_a), .count(count_a), .parityErr(parityErr_a),
    .frameErr(frameErr_a), .overflow(overflow_a), .clrErr(clrErr_a));

  uart_rx_buffered #(.DATA_WIDTH(8), .CLK_FREQ(64_000_000), .BAUD_RATE(1_000_000),
                     .PARITY(2), .STOP_BITS(1), .DEPTH(4)) dut_b (
    .clk(clk), .rstN(rstN), .rx(rx_b), .rdData(rdData_b), .rdValid(rdValid_b),
    .rdReady(rdReady_b), .count(count_b), .parityErr(parityErr_b),
    .frameErr(frameErr_b), .overflow(overflow_b), .clrErr(clrErr_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one line level for clks cycles; tracks the first count change and an optional timed pop.
  task automatic line(input bit sel, input logic v, input int clks);
    for (int i = 0; i < clks; i++) begin
      if (sel) rx_b = v; else rx_a = v;
      if (pop_at >= 0) rdReady_a = (fclk == pop_at);
      @(negedge clk);
      fclk++;
      cur_cnt = sel ? count_b : count_a;
      if (push_at < 0 && cur_cnt != prev_cnt) push_at = fclk;
      if (fclk == pop_at) pre_dat = rdData_a;
      if (fclk == pop_at + 1) begin
        snap_cnt = count_a;
        snap_dat = rdData_a;
        snap_ovf = overflow_a;
      end
    end
  endtask

  task automatic align();
    while (cyc % 4 != 0) @(negedge clk);
    fclk     = 0;
    push_at  = -1;
    prev_cnt = count_a;
  endtask

  task automatic frame(input bit sel, input logic [7:0] d, input bit par_en,
                       input logic par, input logic stop);
    align();
    prev_cnt = sel ? count_b : count_a;
    line(sel, 1'b0, BIT);
    for (int i = 0; i < 8; i++) line(sel, d[i], BIT);
    if (par_en) line(sel, par, BIT);
    line(sel, stop, BIT);
    if (stop) line(sel, 1'b1, 16);
  endtask

  task automatic pulse_clr(input bit sel);
    if (sel) clrErr_b = 1'b1; else clrErr_a = 1'b1;
    @(negedge clk);
    clrErr_a = 1'b0;
    clrErr_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input bit sel);
    while ((sel ? exp_b.size() : exp_a.size()) > 0) begin
      if (sel) e = exp_b.pop_front(); else e = exp_a.pop_front();
      check("drain_vld", sel ? rdValid_b : rdValid_a, 1'b1);
      check("drain_dat", sel ? rdData_b : rdData_a, e);
      if (sel) rdReady_b = 1'b1; else rdReady_a = 1'b1;
      @(negedge clk);
      rdReady_a = 1'b0;
      rdReady_b = 1'b0;
    end
    check("drain_empty", sel ? rdValid_b : rdValid_a, 1'b0);
    check("drain_count", sel ? count_b : count_a, 3'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
    rdReady_a = 1'b0; rdReady_b = 1'b0; clrErr_a = 1'b0; clrErr_b = 1'b0;
    d77 = 8'h77;
    repeat (5) @(negedge clk);
    check("rst_dat", rdData_a, 8'h00);
    check("rst_vld", rdValid_a, 1'b0);
    check("rst_cnt", count_a, 3'd0);
    check("rst_flags", {parityErr_a, frameErr_a, overflow_a}, 3'b000);
    check("rst_b", {rdValid_b, count_b, parityErr_b, frameErr_b, overflow_b}, 7'd0);
    rstN = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 character: one-clock latency after the mid stop-bit sample
    frame(0, 8'hCC, 0, 1'b0, 1'b1);
    exp_a.push_back(8'hCC);
    check("t1_latency", (push_at >= 596 && push_at <= 624), 1'b1);
    check("t1_dat", rdData_a, 8'hCC);
    check("t1_vld", rdValid_a, 1'b1);
    check("t1_cnt", count_a, 3'd1);
    check("t1_flags", {parityErr_a, frameErr_a, overflow_a}, 3'b000);
    drain(0);

    // Even parity: bad parity dropped, good one kept, clrErr clears the flag
    frame(1, 8'h35, 1, 1'b1, 1'b1);
    check("par_bad_flag", parityErr_b, 1'b1);
    check("par_bad_cnt", count_b, 3'd0);
    check("par_bad_frm", frameErr_b, 1'b0);
    frame(1, 8'h35, 1, 1'b0, 1'b1);
    exp_b.push_back(8'h35);
    check("par_ok_cnt", count_b, 3'd1);
    check("par_ok_dat", rdData_b, 8'h35);
    check("par_sticky", parityErr_b, 1'b1);
    pulse_clr(1);
    check("par_clr", parityErr_b, 1'b0);
    drain(1);

    // Low stop bit followed by a held-low line: one drop, no push
    frame(0, 8'hA5, 0, 1'b0, 1'b0);
    line(0, 1'b0, 3 * BIT);
    line(0, 1'b1, 2 * BIT);
    check("frm_flag", frameErr_a, 1'b1);
    check("frm_cnt", count_a, 3'd0);
    check("frm_par", parityErr_a, 1'b0);
    frame(0, 8'h5A, 0, 1'b0, 1'b1);
    exp_a.push_back(8'h5A);
    check("frm_next_cnt", count_a, 3'd1);
    check("frm_next_dat", rdData_a, 8'h5A);
    drain(0);
    pulse_clr(0);
    check("frm_clr", frameErr_a, 1'b0);

    // Overflow: fifth word dropped, first four drained in order
    for (int i = 1; i <= 5; i++) begin
      frame(0, 8'(i), 0, 1'b0, 1'b1);
      if (i <= 4) exp_a.push_back(8'(i));
      if (i == 4) begin
        n04 = push_at;
        check("ovf_full_noflag", overflow_a, 1'b0);
      end
    end
    check("ovf_cnt", count_a, 3'd4);
    check("ovf_flag", overflow_a, 1'b1);
    check("ovf_head", rdData_a, 8'h01);
    drain(0);
    pulse_clr(0);
    check("ovf_clr", overflow_a, 1'b0);

    // Full FIFO with a pop on the push cycle: 06 is accepted, count holds
    for (int i = 1; i <= 4; i++) begin
      frame(0, 8'(i), 0, 1'b0, 1'b1);
      exp_a.push_back(8'(i));
    end
    check("fp_pre_cnt", count_a, 3'd4);
    pop_at = n04 - 1;
    frame(0, 8'h06, 0, 1'b0, 1'b1);
    pop_at = -1;
    rdReady_a = 1'b0;
    e = exp_a.pop_front();
    check("fp_popped", pre_dat, e);
    exp_a.push_back(8'h06);
    check("fp_cnt_hold", snap_cnt, 3'd4);
    check("fp_new_head", snap_dat, 8'h02);
    check("fp_ovf_edge", snap_ovf, 1'b0);
    check("fp_ovf_after", overflow_a, 1'b0);
    drain(0);

    // Short low glitch is a false start
    align();
    line(0, 1'b0, 16);
    line(0, 1'b1, 2 * BIT);
    check("gl_cnt", count_a, 3'd0);
    check("gl_vld", rdValid_a, 1'b0);
    check("gl_flags", {parityErr_a, frameErr_a, overflow_a}, 3'b000);
    frame(0, 8'h3C, 0, 1'b0, 1'b1);
    exp_a.push_back(8'h3C);
    check("gl_next_dat", rdData_a, 8'h3C);
    drain(0);

    // Reset mid-DATA discards the FIFO, flags and the partial word
    frame(0, 8'h11, 0, 1'b0, 1'b0);
    line(0, 1'b1, BIT);
    frame(0, 8'h22, 0, 1'b0, 1'b1);
    check("mr_pre_frm", frameErr_a, 1'b1);
    check("mr_pre_cnt", count_a, 3'd1);
    align();
    line(0, 1'b0, BIT);
    for (int i = 0; i < 3; i++) line(0, d77[i], BIT);
    line(0, d77[3], BIT / 2);
    rstN = 1'b0;
    line(0, d77[3], BIT / 2);
    check("mr_in_cnt", count_a, 3'd0);
    check("mr_in_vld", rdValid_a, 1'b0);
    check("mr_in_dat", rdData_a, 8'h00);
    check("mr_in_flags", {parityErr_a, frameErr_a, overflow_a}, 3'b000);
    for (int i = 4; i < 8; i++) line(0, d77[i], BIT);
    line(0, 1'b1, BIT);
    rstN = 1'b1;
    line(0, 1'b1, 2 * BIT);
    check("mr_post_cnt", count_a, 3'd0);
    check("mr_post_vld", rdValid_a, 1'b0);
    check("mr_post_flags", {parityErr_a, frameErr_a, overflow_a}, 3'b000);
    frame(0, 8'h96, 0, 1'b0, 1'b1);
    exp_a.push_back(8'h96);
    check("mr_next_cnt", count_a, 3'd1);
    drain(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
